// File: rtl/sparse_matmul_scheduler.sv
// rtl/sparse_matmul_scheduler.sv - tile-pair command scheduler that skips all-zero B tiles
//
// Walks the output tile grid (r, c) and the reduction index k (innermost) and
// presents one command per nonzero B tile (k, c). A C tile whose B column has
// no nonzero tile gets a single cmd_zero command in its last k slot.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a pass (IDLE only); mask_data latched on the same edge
//   mask_data       B tile nonzero map, bit k*CT+c
//   cmd_valid/ready command handshake
//   cmd_a_idx       A tile index r*KT+k
//   cmd_b_idx       B tile index k*CT+c
//   cmd_last        final command for C tile (r, c)
//   cmd_zero        C tile (r, c) is all zero
//   busy            pass in progress (ISSUE or FINISH)
//   done            one-cycle end-of-pass pulse
//   skip_count      slots skipped without a command in the current/last pass
module sparse_matmul_scheduler #(
    parameter  int A_DEPTH_DIM0 = 2,
    parameter  int A_DEPTH_DIM1 = 2,
    parameter  int B_DEPTH_DIM0 = 2,
    localparam int KT   = A_DEPTH_DIM0,
    localparam int RT   = A_DEPTH_DIM1,
    localparam int CT   = B_DEPTH_DIM0,
    localparam int A_W  = (RT * KT > 1) ? $clog2(RT * KT) : 1,
    localparam int B_W  = (KT * CT > 1) ? $clog2(KT * CT) : 1,
    localparam int SK_W = $clog2(RT * CT * KT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KT*CT-1:0]   mask_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [A_W-1:0]     cmd_a_idx,
    output logic [B_W-1:0]     cmd_b_idx,
    output logic               cmd_last,
    output logic               cmd_zero,
    output logic               busy,
    output logic               done,
    output logic [SK_W-1:0]    skip_count
);

    localparam int R_W = (RT > 1) ? $clog2(RT) : 1;
    localparam int C_W = (CT > 1) ? $clog2(CT) : 1;
    localparam int K_W = (KT > 1) ? $clog2(KT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, next_state;

    logic [R_W-1:0]   r;
    logic [C_W-1:0]   c;
    logic [K_W-1:0]   k;
    logic             issued;
    logic [KT*CT-1:0] mask_q;

    logic             k_last, c_last, r_last;
    logic             tile_nz;
    logic             later_nz;
    logic [KT*CT-1:0] mask_shift;
    logic             advance;
    logic             pass_end;

    assign k_last = (k == K_W'(KT - 1));
    assign c_last = (c == C_W'(CT - 1));
    assign r_last = (r == R_W'(RT - 1));

    assign cmd_a_idx = A_W'(r) * A_W'(KT) + A_W'(k);
    assign cmd_b_idx = B_W'(k) * B_W'(CT) + B_W'(c);

    assign tile_nz = mask_q[cmd_b_idx];

    // Tiles of the same column further down k sit at multiples of CT above
    // the current bit; bits shifted in past the top are zero, so tiles beyond
    // KT-1 never count.
    assign mask_shift = mask_q >> cmd_b_idx;

    always_comb begin
        later_nz = 1'b0;
        for (int j = 1; j < KT; j++) begin
            later_nz = later_nz | mask_shift[j*CT];
        end
    end

    // An empty slot (no command) always advances; a presented command waits
    // for the handshake.
    assign advance  = (state == ISSUE) && (!cmd_valid || cmd_ready);
    assign pass_end = advance && k_last && c_last && r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   if (pass_end) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_zero  = 1'b0;
        cmd_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ISSUE: begin
                busy = 1'b1;
                if (tile_nz) begin
                    cmd_valid = 1'b1;
                    cmd_last  = !later_nz;
                end else if (k_last && !issued) begin
                    cmd_valid = 1'b1;
                    cmd_zero  = 1'b1;
                    cmd_last  = 1'b1;
                end
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= '0;
            c          <= '0;
            k          <= '0;
            issued     <= 1'b0;
            mask_q     <= '0;
            skip_count <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                mask_q     <= mask_data;
                r          <= '0;
                c          <= '0;
                k          <= '0;
                issued     <= 1'b0;
                skip_count <= '0;
            end
        end else if (advance) begin
            if (!cmd_valid) begin
                skip_count <= skip_count + SK_W'(1);
            end
            if (k_last) begin
                k      <= '0;
                issued <= 1'b0;
                if (c_last) begin
                    c <= '0;
                    if (!r_last) begin
                        r <= r + R_W'(1);
                    end
                end else begin
                    c <= c + C_W'(1);
                end
            end else begin
                k <= k + K_W'(1);
                if (cmd_valid) begin
                    issued <= 1'b1;
                end
            end
        end
    end

endmodule
